rr_dispatcher: RTL

- Round-robin 1-to-N distributor: the fan-out counterpart of the router's N-to-1 round-robin arbiter.
- Accepts one valid/ready input stream and spreads flits across NUM_CLIENTS output lanes, rotating fairly among lanes able to take data.
- Each lane has a one-deep registered output slot.
- Sits at the router egress, feeding parallel consumers (e.g. per-core ports or replicated engines).

---
 rtl/rr_dispatcher_pkg.sv | 17 +
 rtl/rr_dispatcher_select.sv | 45 ++++
 rtl/rr_dispatcher.sv | 101 ++++++++++
 3 files changed

// File: rtl/rr_dispatcher_pkg.sv
// Shared definitions for the round-robin dispatch blocks.
// Holds the pointer-width helper, the counter width and the reset pointer value.
package router_dispatch_pkg;

  // Width of an encoded lane index; never narrower than one bit.
  function automatic int ptr_width(input int num_clients);
    return (num_clients <= 2) ? 1 : $clog2(num_clients);
  endfunction

  // Pointer value after reset: the last lane, so the first flit lands on lane 0.
  function automatic int reset_ptr(input int num_clients);
    return num_clients - 1;
  endfunction

  localparam int DISPATCH_CNT_W = 16;

endpackage

// File: rtl/rr_dispatcher_select.sv
// rr_select: masked find-first with wrap-around for round-robin selection.
// Picks the lowest available lane above last_ptr, else the lowest available lane.
import router_dispatch_pkg::*;

module rr_select #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  avail,
  input  logic [PW-1:0] last_ptr,
  output logic [N-1:0]  sel_onehot,
  output logic [PW-1:0] sel_idx,
  output logic          any
);

  logic [N-1:0] masked;
  logic         found;

  // Search lanes strictly above the pointer first, then wrap to the bottom.
  always_comb begin
    masked     = '0;
    found      = 1'b0;
    sel_onehot = '0;
    sel_idx    = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = avail[i] && (i > int'(last_ptr));
    end
    for (int i = 0; i < N; i++) begin
      if (!found && masked[i]) begin
        found         = 1'b1;
        sel_onehot[i] = 1'b1;
        sel_idx       = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && avail[i]) begin
        found         = 1'b1;
        sel_onehot[i] = 1'b1;
        sel_idx       = PW'(i);
      end
    end
    any = |avail;
  end

endmodule

// File: rtl/rr_dispatcher.sv
// rr_dispatcher: round-robin 1-to-N distributor with a one-deep slot per lane.
// Optional per-lane accept counters are enabled by defining RR_DISPATCHER_CNT_EN.
import router_dispatch_pkg::*;

module rr_dispatcher #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  input  logic [DATA_WIDTH-1:0]                      in_data,
  output logic                                       in_ready,
  output logic [NUM_CLIENTS-1:0]                     out_valid,
  output logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0]     out_data,
  input  logic [NUM_CLIENTS-1:0]                     out_ready,
  output logic [NUM_CLIENTS-1:0][DISPATCH_CNT_W-1:0] dispatch_cnt
);

  localparam int PTR_W = ptr_width(NUM_CLIENTS);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(reset_ptr(NUM_CLIENTS));

  logic [NUM_CLIENTS-1:0]                 slot_full_reg;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] slot_data_reg;
  logic [PTR_W-1:0]                       last_ptr_reg;

  logic [NUM_CLIENTS-1:0] avail;
  logic [NUM_CLIENTS-1:0] sel_onehot;
  logic [PTR_W-1:0]       sel_idx;
  logic                   any_avail;
  logic                   accept;

  // A lane can take data if empty or draining this very cycle.
  assign avail = ~slot_full_reg | out_ready;

  rr_select #(
    .N  (NUM_CLIENTS),
    .PW (PTR_W)
  ) u_select (
    .avail      (avail),
    .last_ptr   (last_ptr_reg),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx),
    .any        (any_avail)
  );

  // Ready is forced low while reset is held so nothing is taken on a reset edge.
  assign in_ready = rst & any_avail;
  assign accept   = in_valid & in_ready;

  assign out_valid = slot_full_reg;
  assign out_data  = slot_data_reg;

  // Slot update: refill wins over drain so a draining lane stays full with new data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_full_reg <= '0;
      slot_data_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (accept && sel_onehot[i]) begin
          slot_full_reg[i] <= 1'b1;
          slot_data_reg[i] <= in_data;
        end else if (out_ready[i]) begin
          slot_full_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Pointer advances only on an actual transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_ptr_reg <= PTR_RST;
    end else if (accept) begin
      last_ptr_reg <= sel_idx;
    end
  end

`ifdef RR_DISPATCHER_CNT_EN
  logic [NUM_CLIENTS-1:0][DISPATCH_CNT_W-1:0] cnt_reg;

  // Saturating per-lane accept counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (accept && sel_onehot[i] && (cnt_reg[i] != {DISPATCH_CNT_W{1'b1}})) begin
          cnt_reg[i] <= cnt_reg[i] + 1'b1;
        end
      end
    end
  end

  assign dispatch_cnt = cnt_reg;
`else
  assign dispatch_cnt = '0;
`endif

endmodule
